// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone/local-master BRAM arbiter.
package wb_bram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OWN_WB = 1'b0;
  localparam logic OWN_LM = 1'b1;

  localparam logic [11:0] DEFAULT_BASE = 12'h380;

  // Wishbone byte selects only become write strobes on a write cycle
  function automatic logic [3:0] wb_strobes(input logic [3:0] sel, input logic we);
    return sel & {4{we}};
  endfunction

endpackage

// File: rtl/wb_bram_arbiter_rr_arb2.sv
// Two-requester round-robin grant: a tie goes to whoever was not served last.
module rr_arb2
  import wb_bram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wb,
  input  logic req_lm,
  input  logic update,
  output logic gnt_valid,
  output logic gnt_owner
);

  logic last_grant_r;

  // Grant select from the current requests and the previous winner
  always_comb begin
    gnt_valid = req_wb | req_lm;
    if (req_wb && req_lm) begin
      gnt_owner = ~last_grant_r;
    end else if (req_wb) begin
      gnt_owner = OWN_WB;
    end else begin
      gnt_owner = OWN_LM;
    end
  end

  // Remember the winner; reset favours WB on the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= OWN_LM;
    end else if (update) begin
      last_grant_r <= gnt_owner;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/wb_bram_arbiter.sv
// Arbitrates the user BRAM between the Wishbone slave port and a local master,
// holding each access for DELAYS wait states and returning a one-cycle ack/ready.
module wb_bram_arbiter
  import wb_bram_pkg::*;
#(
  parameter int unsigned  DELAYS = 2,
  parameter logic [11:0]  BASE   = DEFAULT_BASE,
  parameter int unsigned  LM_AW  = 20
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             lm_valid_i,
  input  logic [3:0]       lm_we_i,
  input  logic [LM_AW-1:0] lm_adr_i,
  input  logic [31:0]      lm_dat_i,
  output logic             lm_ready_o,
  output logic [31:0]      lm_dat_o,
  output logic             bram_en_o,
  output logic [3:0]       bram_we_o,
  output logic [31:0]      bram_adr_o,
  output logic [31:0]      bram_di_o,
  input  logic [31:0]      bram_do_i,
  output logic             busy_o,
  output logic             grant_o
);

  localparam int CNT_W = (DELAYS > 0) ? $clog2(DELAYS + 1) : 1;

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             wb_req_s, lm_req_s;
  logic             arb_valid_s, arb_owner_s;
  logic             take_s, done_s;
  logic             owner_r, wb_abort_r;
  logic             wb_ack_r, lm_ready_r, busy_r;
  logic             bram_en_r;
  logic [3:0]       bram_we_r;
  logic [31:0]      bram_adr_r, bram_di_r, rdata_r;

  assign wb_req_s = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == BASE);
  assign lm_req_s = lm_valid_i;

  rr_arb2 u_arb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req_wb    (wb_req_s),
    .req_lm    (lm_req_s),
    .update    (take_s),
    .gnt_valid (arb_valid_s),
    .gnt_owner (arb_owner_s)
  );

  // Next-state decode; take_s marks a grant, done_s the final wait-state cycle
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          state_s = ACCESS;
          take_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == CNT_W'(DELAYS)) begin
          state_s = RESP;
          done_s  = 1'b1;
        end else begin
          state_s = ACCESS;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch doubles as the BRAM port registers; write strobe lives one cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_r      <= '0;
      owner_r    <= OWN_WB;
      wb_abort_r <= 1'b0;
      wb_ack_r   <= 1'b0;
      lm_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      bram_en_r  <= 1'b0;
      bram_we_r  <= 4'h0;
      bram_adr_r <= 32'h0;
      bram_di_r  <= 32'h0;
      rdata_r    <= 32'h0;
    end else begin
      wb_ack_r   <= 1'b0;
      lm_ready_r <= 1'b0;
      bram_we_r  <= 4'h0;
      busy_r     <= (state_s != IDLE);
      if (take_s) begin
        owner_r    <= arb_owner_s;
        wb_abort_r <= 1'b0;
        cnt_r      <= '0;
        bram_en_r  <= 1'b1;
        if (arb_owner_s == OWN_WB) begin
          bram_adr_r <= wbs_adr_i;
          bram_di_r  <= wbs_dat_i;
          bram_we_r  <= wb_strobes(wbs_sel_i, wbs_we_i);
        end else begin
          bram_adr_r <= 32'({BASE, lm_adr_i});
          bram_di_r  <= lm_dat_i;
          bram_we_r  <= lm_we_i;
        end
      end else if (done_s) begin
        cnt_r      <= '0;
        bram_en_r  <= 1'b0;
        bram_adr_r <= 32'h0;
        bram_di_r  <= 32'h0;
        rdata_r    <= bram_do_i;
        wb_ack_r   <= (owner_r == OWN_WB) && !wb_abort_r && wbs_cyc_i;
        lm_ready_r <= (owner_r == OWN_LM);
      end else if (state_r == ACCESS) begin
        cnt_r <= cnt_r + CNT_W'(1);
        if ((owner_r == OWN_WB) && !wbs_cyc_i) begin
          wb_abort_r <= 1'b1;
        end else begin
          wb_abort_r <= wb_abort_r;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // A master that drops cyc during the response cycle must not see the ack
  assign wbs_ack_o  = wb_ack_r & wbs_cyc_i;
  assign wbs_dat_o  = rdata_r;
  assign lm_ready_o = lm_ready_r;
  assign lm_dat_o   = rdata_r;
  assign bram_en_o  = bram_en_r;
  assign bram_we_o  = bram_we_r;
  assign bram_adr_o = bram_adr_r;
  assign bram_di_o  = bram_di_r;
  assign busy_o     = busy_r;
  assign grant_o    = owner_r;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Self-checking bench for wb_bram_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level memory/arbitration model.
module tb_wb_bram_arbiter;

  localparam int DELAYS = 2;
  localparam int LAT    = DELAYS + 2;
  localparam logic TB_WB = 1'b0;
  localparam logic TB_LM = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic        lm_valid_i;
  logic [3:0]  lm_we_i;
  logic [19:0] lm_adr_i;
  logic [31:0] lm_dat_i, lm_dat_o;
  logic        lm_ready_o;
  logic        bram_en_o;
  logic [3:0]  bram_we_o;
  logic [31:0] bram_adr_o, bram_di_o, bram_do_i;
  logic        busy_o, grant_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_clr;
  logic        last_own;
  int          we_cnt = 0, ack_cnt = 0, rdy_cnt = 0, en_cnt = 0;

  logic [31:0] t_wrd, t_lrd;
  int          t_wlat, t_llat;
  logic        t_wown, t_lown;

  always #5 clk = ~clk;

  wb_bram_arbiter #(.DELAYS(DELAYS), .BASE(12'h380), .LM_AW(20)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .lm_valid_i(lm_valid_i), .lm_we_i(lm_we_i), .lm_adr_i(lm_adr_i),
    .lm_dat_i(lm_dat_i), .lm_ready_o(lm_ready_o), .lm_dat_o(lm_dat_o),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_adr_o(bram_adr_o),
    .bram_di_o(bram_di_o), .bram_do_i(bram_do_i),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  // Behavioural BRAM: byte-write, registered read-before-write
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) mem[bram_adr_o[9:2]][8*b +: 8] <= bram_di_o[8*b +: 8];
      bram_do_i <= mem[bram_adr_o[9:2]];
    end
  end

  // Event counters for pulse-width and no-activity checks
  always @(posedge clk) begin
    if (bram_we_o != 4'h0) we_cnt <= we_cnt + 1;
    if (wbs_ack_o)         ack_cnt <= ack_cnt + 1;
    if (lm_ready_o)        rdy_cnt <= rdy_cnt + 1;
    if (bram_en_o)         en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] wb_addr(input logic [7:0] idx);
    return 32'h3800_0000 + {22'h0, idx, 2'b00};
  endfunction

  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] rd, output int lat,
                         output logic own);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    lat = 0; rd = 32'h0; own = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        lat = i; rd = wbs_dat_o; own = grant_o;
        break;
      end
    end
    if (lat == 0) chk("wb_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic lm_xfer(input logic [3:0] we, input logic [19:0] adr, input logic [31:0] dat,
                         output logic [31:0] rd, output int lat, output logic own);
    lm_valid_i = 1'b1; lm_we_i = we; lm_adr_i = adr; lm_dat_i = dat;
    lat = 0; rd = 32'h0; own = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (lm_ready_o) begin
        lat = i; rd = lm_dat_o; own = grant_o;
        break;
      end
    end
    if (lat == 0) chk("lm_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    lm_valid_i = 1'b0; lm_we_i = 4'h0;
  endtask

  task automatic do_wb(input logic we, input logic [3:0] sel, input logic [7:0] idx,
                       input logic [31:0] dat, input string tag, output logic [31:0] rd);
    logic [31:0] exp;
    exp = ref_mem[idx];
    wb_xfer(we, sel, wb_addr(idx), dat, rd, t_wlat, t_wown);
    chk({tag, "_lat"}, 32'(t_wlat), 32'(LAT));
    chk({tag, "_own"}, {31'h0, t_wown}, {31'h0, TB_WB});
    if (we) ref_mem[idx] = merge(ref_mem[idx], dat, sel);
    else    chk({tag, "_rd"}, rd, exp);
    last_own = TB_WB;
  endtask

  task automatic do_lm(input logic [3:0] we, input logic [7:0] idx, input logic [31:0] dat,
                       input string tag, output logic [31:0] rd);
    logic [31:0] exp;
    exp = ref_mem[idx];
    lm_xfer(we, {10'h0, idx, 2'b00}, dat, rd, t_llat, t_lown);
    chk({tag, "_lat"}, 32'(t_llat), 32'(LAT));
    chk({tag, "_own"}, {31'h0, t_lown}, {31'h0, TB_LM});
    if (we != 4'h0) ref_mem[idx] = merge(ref_mem[idx], dat, we);
    else            chk({tag, "_rd"}, rd, exp);
    last_own = TB_LM;
  endtask

  task automatic do_both(input logic wwe, input logic [3:0] wsel, input logic [7:0] widx,
                         input logic [31:0] wdat, input logic [3:0] lwe, input logic [7:0] lidx,
                         input logic [31:0] ldat, input string tag, output logic winner);
    logic [31:0] wexp, lexp;
    logic        exp_win;
    exp_win = (last_own == TB_LM) ? TB_WB : TB_LM;
    fork
      wb_xfer(wwe, wsel, wb_addr(widx), wdat, t_wrd, t_wlat, t_wown);
      lm_xfer(lwe, {10'h0, lidx, 2'b00}, ldat, t_lrd, t_llat, t_lown);
    join
    winner = (t_llat < t_wlat) ? TB_LM : TB_WB;
    chk({tag, "_win"}, {31'h0, winner}, {31'h0, exp_win});
    if (exp_win == TB_WB) begin
      wexp = ref_mem[widx];
      if (wwe) ref_mem[widx] = merge(ref_mem[widx], wdat, wsel);
      lexp = ref_mem[lidx];
      ref_mem[lidx] = merge(ref_mem[lidx], ldat, lwe);
    end else begin
      lexp = ref_mem[lidx];
      ref_mem[lidx] = merge(ref_mem[lidx], ldat, lwe);
      wexp = ref_mem[widx];
      if (wwe) ref_mem[widx] = merge(ref_mem[widx], wdat, wsel);
    end
    chk({tag, "_wlat"}, 32'(t_wlat), 32'((exp_win == TB_WB) ? LAT : 2*LAT + 1));
    chk({tag, "_llat"}, 32'(t_llat), 32'((exp_win == TB_LM) ? LAT : 2*LAT + 1));
    chk({tag, "_wown"}, {31'h0, t_wown}, {31'h0, TB_WB});
    chk({tag, "_lown"}, {31'h0, t_lown}, {31'h0, TB_LM});
    if (!wwe)       chk({tag, "_wrd"}, t_wrd, wexp);
    if (lwe == 4'h0) chk({tag, "_lrd"}, t_lrd, lexp);
    last_own = (exp_win == TB_WB) ? TB_LM : TB_WB;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  {31'h0, wbs_ack_o}, 32'h0);
    chk({tag, "_wdat"}, wbs_dat_o, 32'h0);
    chk({tag, "_rdy"},  {31'h0, lm_ready_o}, 32'h0);
    chk({tag, "_ldat"}, lm_dat_o, 32'h0);
    chk({tag, "_en"},   {31'h0, bram_en_o}, 32'h0);
    chk({tag, "_we"},   {28'h0, bram_we_o}, 32'h0);
    chk({tag, "_adr"},  bram_adr_o, 32'h0);
    chk({tag, "_di"},   bram_di_o, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
    chk({tag, "_gnt"},  {31'h0, grant_o}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        win;
    int          base_a, base_e, base_r, base_w;
    logic        wwe;
    logic [3:0]  wsel, lwe;
    logic [7:0]  widx, lidx;
    logic [31:0] wdat, ldat;
    int          mode;

    rst = 1'b1; mem_clr = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    lm_valid_i = 1'b0; lm_we_i = 4'h0; lm_adr_i = 20'h0; lm_dat_i = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    last_own = TB_LM;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;
    chk_all_zero("reset");

    // Simultaneous requests alternate, WB first after reset
    do_both(1'b0, 4'h0, 8'd4, 32'h0, 4'h0, 8'd8, 32'h0, "tie1", win);
    chk("tie1_first_wb", {31'h0, win}, 32'h0);
    do_both(1'b0, 4'h0, 8'd4, 32'h0, 4'h0, 8'd8, 32'h0, "tie2", win);
    chk("tie2_first_wb", {31'h0, win}, 32'h0);

    // WB write then read
    base_w = we_cnt;
    do_wb(1'b1, 4'hF, 8'h04, 32'hDEADBEEF, "wbwr", rd);
    chk("wbwr_we_pulse", 32'(we_cnt - base_w), 32'd1);
    do_wb(1'b0, 4'hF, 8'h04, 32'h0, "wbrd", rd);
    chk("wbrd_const", rd, 32'hDEADBEEF);

    // Partial LM write over existing data
    do_wb(1'b1, 4'hF, 8'h04, 32'h11223344, "pw_init", rd);
    do_lm(4'b0001, 8'h04, 32'h000000AA, "pw_lm", rd);
    do_wb(1'b0, 4'hF, 8'h04, 32'h0, "pw_rd", rd);
    chk("pw_const", rd, 32'h112233AA);

    // Non-decoded WB access is ignored; LM still served
    base_a = ack_cnt; base_e = en_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0000;
    repeat (20) @(posedge clk);
    #1;
    chk("nd_no_ack", 32'(ack_cnt - base_a), 32'd0);
    chk("nd_no_en", 32'(en_cnt - base_e), 32'd0);
    chk("nd_busy", {31'h0, busy_o}, 32'h0);
    do_lm(4'h0, 8'h04, 32'h0, "nd_lm", rd);
    chk("nd_no_ack2", 32'(ack_cnt - base_a), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

    // Reset during an LM read
    base_r = rdy_cnt;
    lm_valid_i = 1'b1; lm_we_i = 4'h0; lm_adr_i = 20'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rm_in_access", {31'h0, busy_o}, 32'h1);
    rst = 1'b1; lm_valid_i = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rm");
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rm_no_ready", 32'(rdy_cnt - base_r), 32'd0);
    last_own = TB_LM;
    do_both(1'b0, 4'h0, 8'd4, 32'h0, 4'h0, 8'd4, 32'h0, "rm_tie", win);
    chk("rm_tie_wb", {31'h0, win}, 32'h0);

    // WB abort during ACCESS of a write
    base_a = ack_cnt;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3800_0020; wbs_dat_i = 32'h5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("ab_no_ack", 32'(ack_cnt - base_a), 32'd0);
    ref_mem[8] = 32'h5;
    last_own = TB_WB;
    do_wb(1'b0, 4'hF, 8'h08, 32'h0, "ab_rd", rd);
    chk("ab_const", rd, 32'h5);

    // Randomized mixed traffic
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      wwe  = 1'($urandom_range(0, 1));
      wsel = 4'($urandom);
      widx = 8'($urandom_range(0, 15));
      wdat = $urandom;
      lwe  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      lidx = 8'($urandom_range(0, 15));
      ldat = $urandom;
      if (mode == 0)      do_wb(wwe, wsel, widx, wdat, "rnd_wb", rd);
      else if (mode == 1) do_lm(lwe, lidx, ldat, "rnd_lm", rd);
      else                do_both(wwe, wsel, widx, wdat, lwe, lidx, ldat, "rnd_tie", win);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bram_arbiter.md
Name: wb_bram_arbiter

Overview:
- Shares the single user BRAM between the Wishbone slave port and one local master, for example a future accelerator engine.
- Grants one requester at a time, using round-robin arbitration on ties.
- Sequences the fixed-latency BRAM access by holding it for DELAYS wait states.
- Returns the registered read data with a one-cycle ack/ready pulse.
- Sits between the Wishbone MI A interface of user_proj_example and the bram instance. It replaces the ad-hoc ready/delayed_count logic there.

Parameters:
- DELAYS, 2: wait-state cycles; bram_do_i is sampled on the DELAYS-th ACCESS cycle after the first.
- BASE, 12'h380: required wbs_adr_i[31:20] for a Wishbone decode hit.
- LM_AW, 20: local master byte-address width.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone strobes
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle ack
- wbs_dat_o  out  32  read data
- lm_valid_i  in  1  local master request
- lm_we_i  in  4  byte write enables; 0 means read
- lm_adr_i  in  LM_AW  byte address
- lm_dat_i  in  32  write data
- lm_ready_o  out  1  one-cycle completion
- lm_dat_o  out  32  read data
- bram_en_o  out  1  to bram EN0
- bram_we_o  out  4  to bram WE0
- bram_adr_o  out  32  to bram A0
- bram_di_o  out  32  to bram Di0
- bram_do_i  in  32  from bram Do0
- busy_o  out  1  high when not IDLE
- grant_o  out  1  current/last owner: 0 = WB, 1 = LM

Behaviour:
- Reset: all outputs are 0 and state is IDLE. delay_cnt = 0. last_grant = 1, so the first tie goes to WB.
- Reset asserted mid-transaction aborts with no ack/ready. A BRAM write already issued stays committed.
- Requests:
  - wb_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20]==BASE).
  - lm_req = lm_valid_i.
  - A non-decoded WB cycle is ignored and never acked.
- IDLE:
  - If exactly one request is present, grant it.
  - If both are present, grant the requester that is not last_grant.
  - On grant, latch the request into internal registers: owner, address, write data, and strobes. WB strobes are wbs_sel_i & {4{wbs_we_i}}. The LM address is {BASE, lm_adr_i} zero-extended to 32 bits.
  - Update last_grant and go to ACCESS. Inputs need only be valid in the grant cycle.
- ACCESS:
  - bram_en_o = 1 and bram_adr_o/bram_di_o come from the latched values.
  - bram_we_o = latched strobes on the first ACCESS cycle only, 0 afterwards. This gives exactly one write edge.
  - delay_cnt increments from 0. When delay_cnt == DELAYS, register bram_do_i into a shared rdata register, clear delay_cnt, and go to RESP.
  - The ACCESS duration is DELAYS+1 cycles.
- RESP:
  - Pulse wbs_ack_o or lm_ready_o (owner only) for exactly one cycle, then go to IDLE.
  - wbs_dat_o and lm_dat_o both show rdata and hold until the next capture.
  - For writes, rdata is still captured (BRAM read-during-write value) and is don't-care to masters.
- Latency: request sampled in IDLE at cycle t gives ack/ready at t+DELAYS+2. Minimum issue spacing is DELAYS+3 cycles, because RESP returns to IDLE and re-arbitrates there.
- WB abort: if wbs_cyc_i drops during ACCESS/RESP, the sequence completes but wbs_ack_o is suppressed.
- No re-grant in RESP. A requester still asserting after its ack is treated as a new request in the next IDLE; WB masters drop stb after ack.
- DELAYS=0 is legal: ACCESS lasts one cycle.
- The bram_adr_o upper bits are passed through. The BRAM ignores bits it does not decode.

Decomposition:
- Package wb_bram_pkg:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Owner constants OWN_WB=1'b0, OWN_LM=1'b1.
  - Default BASE.
- One natural sub-module, rr_arb2: two-request round-robin grant with a last_grant register and an update-on-grant input. It is purely sequential plus combinational select.
- FSM, latches, and delay counter stay in the top.

Test Plan:
- WB write then read:
  - Stimulus: WB writes 0xDEADBEEF to 0x38000010 (sel=4'hF), then reads it back (DELAYS=2).
  - Required: ack 4 cycles after each request sample; readback gives 0xDEADBEEF; bram_we_o is nonzero for exactly 1 cycle.
- Simultaneous requests:
  - Stimulus: WB and LM request in the same cycle after reset; both then request again.
  - Required: WB served first (grant_o=0), then LM; on the next simultaneous pair, WB again, i.e. strict alternation.
- Partial write:
  - Stimulus: LM writes 0x000000AA with lm_we_i=4'b0001 to lm_adr_i=0x10 over existing 0x11223344.
  - Required: a WB read of 0x38000010 returns 0x112233AA.
- Non-decoded WB access:
  - Stimulus: WB strobes address 0x30000000.
  - Required: no ack for 20 cycles; bram_en_o stays 0; a pending LM request is served normally.
- Reset mid-transaction:
  - Stimulus: assert wb_rst_i during ACCESS of an LM read.
  - Required: no lm_ready_o; all outputs 0 the next cycle; busy_o=0; the next tie grants WB.
- WB abort:
  - Stimulus: drop wbs_cyc_i during ACCESS of a write to 0x38000020 with data 0x5.
  - Required: no ack; the location still reads 0x5.
